// File: rtl/dec_stage.sv
// RV32I/RV32E decode stage: combinational decode captured into a registered output
// slot, with an optional skid entry so in_ready can come straight from a flop.
module dec_stage #(
    parameter int E_MODE = 0,
    parameter int SKID = 1,
    localparam int REG_ID_W = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [REG_ID_W-1:0] rd,
    output logic [REG_ID_W-1:0] rs1,
    output logic [REG_ID_W-1:0] rs2,
    output logic [31:0]         imm,
    output logic [3:0]          alu_op,
    output logic [2:0]          br_funct,
    output logic [3:0]          mem_wbmask,
    output logic                is_mem_sign,
    output logic [3:0]          inst_type,
    output logic                reg_we,
    output logic                ebreak,
    output logic                ecall,
    output logic                illegal
);

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    // Load types occupy codes 0..3 as {0, funct3[1:0]}.
    typedef enum logic [3:0] {
        INST_IMM    = 4'd4,
        INST_REG    = 4'd5,
        INST_STORE  = 4'd6,
        INST_UPP    = 4'd7,
        INST_JUMP   = 4'd8,
        INST_BRANCH = 4'd9,
        INST_JAL    = 4'd10,
        INST_AUIPC  = 4'd11,
        INST_NOP    = 4'd12
    } inst_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_MAIN,
        OCC_FULL
    } occ_e;

    typedef struct packed {
        logic [31:0]         pc;
        logic [REG_ID_W-1:0] rd;
        logic [REG_ID_W-1:0] rs1;
        logic [REG_ID_W-1:0] rs2;
        logic [31:0]         imm;
        logic [3:0]          alu_op;
        logic [2:0]          br_funct;
        logic [3:0]          mem_wbmask;
        logic                is_mem_sign;
        logic [3:0]          inst_type;
        logic                reg_we;
        logic                ebreak;
        logic                ecall;
        logic                illegal;
    } dec_t;

    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]  f3;
    logic [3:0]  kind, wbmask;
    logic        legal, writes, use_rd, use_rs1, use_rs2;
    dec_t        dec, main_q, skid_q;
    occ_e        state, state_d;
    logic        accept, pop, main_load, main_from_skid, skid_load;

    assign f3    = in_inst[14:12];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec             = '0;
        dec.pc          = in_pc;
        dec.rd          = in_inst[11:7];
        dec.rs1         = in_inst[19:15];
        dec.rs2         = in_inst[24:20];
        dec.is_mem_sign = ~f3[2];
        legal   = 1'b1;
        writes  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        kind    = INST_NOP;
        wbmask  = '0;
        case (in_inst[6:0])
            OPC_LOAD: begin
                dec.imm = imm_i;
                kind    = {2'b00, f3[1:0]};
                writes  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                legal   = !(f3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_MISC_MEM: kind = INST_NOP;
            OPC_OP_IMM: begin
                dec.imm    = imm_i;
                dec.alu_op = {in_inst[30] & (f3 == 3'b101), f3};
                kind       = INST_IMM;
                writes     = 1'b1;
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u;
                kind    = INST_AUIPC;
                writes  = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_STORE: begin
                dec.imm = imm_s;
                kind    = INST_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal   = (f3 <= 3'b010);
                case (f3)
                    3'b000:  wbmask = 4'b0001;
                    3'b001:  wbmask = 4'b0011;
                    3'b010:  wbmask = 4'b1111;
                    default: wbmask = 4'b0000;
                endcase
            end
            OPC_OP: begin
                dec.alu_op = {in_inst[30], f3};
                kind       = INST_REG;
                writes     = 1'b1;
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_LUI: begin
                dec.imm = imm_u;
                kind    = INST_UPP;
                writes  = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm      = imm_b;
                dec.br_funct = f3;
                kind         = INST_BRANCH;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                legal        = !(f3 inside {3'b010, 3'b011});
            end
            OPC_JALR: begin
                dec.imm = imm_i;
                kind    = INST_JUMP;
                writes  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                legal   = (f3 == 3'b000);
            end
            OPC_JAL: begin
                dec.imm = imm_j;
                kind    = INST_JAL;
                writes  = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_SYSTEM: legal = (in_inst == ECALL_WORD) || (in_inst == EBREAK_WORD);
            default:    legal = 1'b0;
        endcase
        // RV32E only has x0..x15; unused fields may hold anything.
        if (E_MODE != 0 && ((use_rd && in_inst[11]) || (use_rs1 && in_inst[19]) ||
                            (use_rs2 && in_inst[24])))
            legal = 1'b0;
        dec.illegal    = ~legal;
        dec.inst_type  = legal ? kind : INST_NOP;
        dec.mem_wbmask = legal ? wbmask : 4'b0000;
        dec.reg_we     = legal & writes & (in_inst[11:7] != '0);
        dec.ebreak     = legal & (in_inst == EBREAK_WORD);
        dec.ecall      = legal & (in_inst == ECALL_WORD);
    end

    assign out_valid = (state != OCC_EMPTY);
    assign in_ready  = (SKID != 0) ? (state != OCC_FULL) : ((state == OCC_EMPTY) || out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = (state != OCC_EMPTY) & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= OCC_EMPTY;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state_d = OCC_MAIN;
                OCC_MAIN: begin
                    if (pop && !accept)      state_d = OCC_EMPTY;
                    else if (!pop && accept) state_d = OCC_FULL;
                end
                OCC_FULL:  if (pop && !accept) state_d = OCC_MAIN;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    // On a pop from FULL the older skid entry moves up and a new beat refills skid.
    always_comb begin
        main_load      = accept && ((state == OCC_EMPTY) || (state == OCC_MAIN && pop));
        main_from_skid = !flush && (state == OCC_FULL) && pop;
        skid_load      = accept && ((state == OCC_MAIN && !pop) || (state == OCC_FULL && pop));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load)           main_q <= dec;
            else if (main_from_skid) main_q <= skid_q;
            if (skid_load)           skid_q <= dec;
        end
    end

    assign out_pc      = main_q.pc;
    assign rd          = main_q.rd;
    assign rs1         = main_q.rs1;
    assign rs2         = main_q.rs2;
    assign imm         = main_q.imm;
    assign alu_op      = main_q.alu_op;
    assign br_funct    = main_q.br_funct;
    assign mem_wbmask  = main_q.mem_wbmask;
    assign is_mem_sign = main_q.is_mem_sign;
    assign inst_type   = main_q.inst_type;
    assign reg_we      = main_q.reg_we;
    assign ebreak      = main_q.ebreak;
    assign ecall       = main_q.ecall;
    assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Scoreboard bench for dec_stage (RV32E, skid buffer): directed decode vectors,
// back-pressure ordering, flush and asynchronous reset behaviour.
module tb_dec_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready, out_valid, is_mem_sign, reg_we, ebreak, ecall, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_op, mem_wbmask, inst_type;
    logic [2:0]  br_funct;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  br;
        logic [3:0]  wb;
        logic        sign;
        logic [3:0]  ty;
        logic        we;
        logic        eb;
        logic        ec;
        logic        il;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t vec[15];
    logic [31:0] vinst[15];

    dec_stage #(.E_MODE(1), .SKID(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op), .br_funct(br_funct),
        .mem_wbmask(mem_wbmask), .is_mem_sign(is_mem_sign), .inst_type(inst_type),
        .reg_we(reg_we), .ebreak(ebreak), .ecall(ecall), .illegal(illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] f_rd, input logic [4:0] f_rs1,
                                input logic [4:0] f_rs2, input logic [31:0] f_imm,
                                input logic [3:0] f_alu, input logic [2:0] f_br,
                                input logic [3:0] f_wb, input logic f_sign,
                                input logic [3:0] f_ty, input logic f_we,
                                input logic f_eb, input logic f_ec, input logic f_il);
        exp_t e;
        e = '{pc: 32'h0, rd: f_rd, rs1: f_rs1, rs2: f_rs2, imm: f_imm, alu: f_alu, br: f_br,
              wb: f_wb, sign: f_sign, ty: f_ty, we: f_we, eb: f_eb, ec: f_ec, il: f_il};
        return e;
    endfunction

    // Must be called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e,
                        output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(negedge clock);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1 (pc 0x%08h)",
                     stalls, pc);
        end else begin
            e.pc = pc;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: pc 0x%08h presented, required none", out_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("pc",          out_pc,                 mon_e.pc);
                chk("rd",          32'(rd),                32'(mon_e.rd));
                chk("rs1",         32'(rs1),               32'(mon_e.rs1));
                chk("rs2",         32'(rs2),               32'(mon_e.rs2));
                chk("imm",         imm,                    mon_e.imm);
                chk("alu_op",      32'(alu_op),            32'(mon_e.alu));
                chk("br_funct",    32'(br_funct),          32'(mon_e.br));
                chk("mem_wbmask",  32'(mem_wbmask),        32'(mon_e.wb));
                chk("is_mem_sign", 32'(is_mem_sign),       32'(mon_e.sign));
                chk("inst_type",   32'(inst_type),         32'(mon_e.ty));
                chk("flags",       32'({reg_we, ebreak, ecall, illegal}),
                                   32'({mon_e.we, mon_e.eb, mon_e.ec, mon_e.il}));
            end
        end
    end

    initial begin
        int st;
        int stall_sum;
        //                 rd     rs1    rs2    imm             alu     br     wb       sg    ty     we    eb    ec    il
        vinst[0]  = 32'h00500093; vec[0]  = mk(5'd1,  5'd0, 5'd5, 32'h0000_0005, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0);
        vinst[1]  = 32'h402081B3; vec[1]  = mk(5'd3,  5'd1, 5'd2, 32'h0000_0000, 4'b1000, 3'd0, 4'b0000, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0);
        vinst[2]  = 32'h4032D293; vec[2]  = mk(5'd5,  5'd5, 5'd3, 32'h0000_0403, 4'b1101, 3'd0, 4'b0000, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0);
        vinst[3]  = 32'hFE208EE3; vec[3]  = mk(5'd29, 5'd1, 5'd2, 32'hFFFF_FFFC, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0);
        vinst[4]  = 32'h00100073; vec[4]  = mk(5'd0,  5'd0, 5'd1, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        vinst[5]  = 32'h00000073; vec[5]  = mk(5'd0,  5'd0, 5'd0, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0);
        vinst[6]  = 32'h00200073; vec[6]  = mk(5'd0,  5'd0, 5'd2, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        vinst[7]  = 32'h00000833; vec[7]  = mk(5'd16, 5'd0, 5'd0, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        vinst[8]  = 32'h0020A423; vec[8]  = mk(5'd8,  5'd1, 5'd2, 32'h0000_0008, 4'b0000, 3'd0, 4'b1111, 1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0);
        vinst[9]  = 32'h0000C283; vec[9]  = mk(5'd5,  5'd1, 5'd0, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        vinst[10] = 32'h0000B283; vec[10] = mk(5'd5,  5'd1, 5'd0, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        vinst[11] = 32'h008000EF; vec[11] = mk(5'd1,  5'd0, 5'd8, 32'h0000_0008, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        vinst[12] = 32'h123453B7; vec[12] = mk(5'd7,  5'd8, 5'd3, 32'h1234_5000, 4'b0000, 3'd0, 4'b0000, 1'b0, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        vinst[13] = 32'h0000000F; vec[13] = mk(5'd0,  5'd0, 5'd0, 32'h0000_0000, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        vinst[14] = 32'h00209463; vec[14] = mk(5'd8,  5'd1, 5'd2, 32'h0000_0008, 4'b0000, 3'd1, 4'b0000, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0);

        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_payload",   out_pc | imm | 32'(inst_type) | 32'(rd), 32'd0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Single addi: visible one cycle after the accepting edge.
        send(vinst[0], 32'h0000_0100, vec[0], st);
        @(negedge clock);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("latency_rd",        32'(rd),        32'd1);
        @(posedge clock);
        #1;

        // Back-to-back stream with out_ready high: no stalls allowed.
        stall_sum = 0;
        for (int i = 1; i < 15; i++) begin
            send(vinst[i], 32'h0000_0200 + 32'(4 * i), vec[i], st);
            stall_sum += st;
        end
        chk("throughput_stalls", 32'(stall_sum), 32'd0);
        repeat (3) @(posedge clock);
        #1;

        // Back-pressure: third beat must see in_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vinst[0];
        in_pc     = 32'h0000_0300;
        @(negedge clock);
        chk("skid_ready_a", 32'(in_ready), 32'd1);
        sb.push_back(exp_t'({32'h0000_0300, vec[0][$bits(exp_t)-33:0]}));
        @(posedge clock);
        #1;
        in_inst = vinst[1];
        in_pc   = 32'h0000_0304;
        @(negedge clock);
        chk("skid_ready_b", 32'(in_ready), 32'd1);
        sb.push_back(exp_t'({32'h0000_0304, vec[1][$bits(exp_t)-33:0]}));
        @(posedge clock);
        #1;
        in_inst = vinst[8];
        in_pc   = 32'h0000_0308;
        @(negedge clock);
        chk("skid_ready_c",   32'(in_ready), 32'd0);
        chk("stall_pc_hold1", out_pc,        32'h0000_0300);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("stall_pc_hold2", out_pc, 32'h0000_0300);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("drain_first_valid",  32'(out_valid), 32'd1);
        @(negedge clock);
        chk("drain_second_valid", 32'(out_valid), 32'd1);
        chk("drain_second_pc",    out_pc,         32'h0000_0304);
        chk("drain_in_ready",     32'(in_ready),  32'd1);
        @(negedge clock);
        chk("drain_empty", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;

        // Flush with both slots full and a beat on offer.
        out_ready = 1'b0;
        send(vinst[2], 32'h0000_0400, vec[2], st);
        send(vinst[3], 32'h0000_0404, vec[3], st);
        in_valid = 1'b1;
        in_inst  = vinst[4];
        in_pc    = 32'h0000_0408;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clock);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        @(posedge clock);
        #1;
        // Flush while empty drops a beat that would otherwise be accepted.
        in_valid = 1'b1;
        in_inst  = vinst[5];
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("flush_drop_beat", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        send(vinst[12], 32'h0000_0500, vec[12], st);
        repeat (3) @(posedge clock);
        #1;

        // Asynchronous reset with both slots occupied.
        out_ready = 1'b0;
        send(vinst[1], 32'h0000_0600, vec[1], st);
        send(vinst[11], 32'h0000_0604, vec[11], st);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd1);
        chk("async_rst_payload",   out_pc | imm | 32'(rd) | 32'(alu_op), 32'd0);
        chk("async_rst_flags",     32'({reg_we, ebreak, ecall, illegal}), 32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("after_rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_stage.md
# dec_stage

Registered, parametrised RV32I/RV32E instruction decode stage with a valid/ready handshake on both sides. It sits between fetch and execute in the miniRV core. It covers every RV32I base opcode (branches, JAL, AUIPC, FENCE, ECALL) and flags illegal encodings. It registers ebreak/ecall as qualified outputs rather than clock-gated combinational signals. An optional skid buffer sustains one instruction per cycle under back-pressure.

## Interface
- E_MODE, 0 — 0: RV32I, 32 registers; 1: RV32E, any used register index with bit 4 set is illegal.
- SKID, 1 — 1: two-entry output (main + skid), in_ready registered; 0: single register, in_ready combinational.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries and the beat offered this cycle.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_inst / in_pc  in  32 / 32  instruction word and its PC.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_pc  out  32  PC of the decoded instruction.
- rd, rs1, rs2  out  REG_ID_W (5 each)  register fields, passed through raw.
- imm  out  32  sign-extended immediate for the format; 0 for R-type and ENV.
- alu_op  out  4  OP: {inst[30], funct3}; OP-IMM: {inst[30] & funct3==101, funct3}; all others 0 (add).
- br_funct  out  3  funct3 for BRANCH, else 0.
- mem_wbmask  out  4  SB 0001, SH 0011, SW 1111, else 0000.
- is_mem_sign  out  1  !funct3[2].
- inst_type  out  4  defs.vh codes: existing INST_IMM/REG/STORE/UPP/JUMP and load codes {0,funct3[1:0]}, zero-extended; new INST_BRANCH, INST_JAL, INST_AUIPC, INST_NOP are added to defs.vh.
- reg_we, ebreak, ecall, illegal  out  1 each  decode flags.

## Operation
- Decode logic is combinational on in_inst. The result and in_pc are captured on the accepting edge (in_valid & in_ready & !flush).
- Immediate formats: I for OP-IMM, LOAD and JALR; S for STORE; B for BRANCH; U for LUI and AUIPC; J for JAL. Bit 0 of the B and J immediates is 0.
- illegal = 1 in any of these cases:
  - inst[1:0] != 11, or an unknown opcode.
  - LOAD funct3 ∈ {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 ∈ {010, 011}.
  - JALR funct3 != 000.
  - ENV word other than exactly 0x00000073 or 0x00100073.
  - With E_MODE=1, rd/rs1/rs2 bit 4 set in a field the format uses.
- When illegal = 1, reg_we, ebreak, ecall and mem_wbmask are forced to 0, and inst_type = INST_NOP.
- MISC-MEM (FENCE) decodes as INST_NOP, legal, with no side effects.
- reg_we = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR when rd != 0.
- ebreak = 1 only for 0x00100073; ecall = 1 only for 0x00000073. Both are meaningful only while out_valid.
- SKID=1:
  - in_ready = !skid_full (registered).
  - Accept while main is full and !out_ready: the entry goes to skid.
  - On an out_ready pop, skid moves to main; a simultaneous new accept goes to whichever slot frees, preserving order.
- SKID=0: in_ready = !out_valid | out_ready.

## Timing
- Latency: 1 cycle from acceptance to out_valid. Throughput is 1/cycle with out_ready held high, for both SKID values.
- Output payload is stable while out_valid & !out_ready. out_valid never drops without a handshake or flush.
- Reset (reset_n low, asynchronous): out_valid = 0, skid empty, every payload output = 0. in_ready = 1 during reset and after release.
- flush: out_valid = 0 and skid empty on the next edge. in_ready stays/returns to 1. The same-cycle input beat is dropped. flush has priority over accept and pop.
- Reset asserted mid-transfer discards all entries immediately; no partial state survives.

## Test plan
- addi x1,x0,5 (0x00500093): rd=1, imm=0x00000005, alu_op=0000, reg_we=1, inst_type=INST_IMM, one cycle after accept.
- sub x3,x1,x2 (0x402081B3) → alu_op=1000, imm=0. srai x5,x5,3 (0x4032D293) → alu_op=1101, imm=0x00000403.
- beq x1,x2,-4 (0xFE208EE3): imm=0xFFFFFFFC, br_funct=000, reg_we=0, inst_type=INST_BRANCH.
- ebreak (0x00100073) → ebreak=1, ecall=0. Word 0x00200073 → illegal=1, ebreak=0. With E_MODE=1, add x16,x0,x0 (0x00000833) → illegal=1, reg_we=0.
- SKID=1, out_ready held low with 3 back-to-back beats: 2 accepted, in_ready=0 on the third. Release out_ready: beats emerge in order on consecutive cycles, with no loss or duplication.
- Flush with 2 held entries plus 1 offered beat → out_valid=0 next cycle, in_ready=1. Assert reset_n low mid-stream → all outputs 0 asynchronously.
